// File: rtl/core_task_arbiter_if.sv
// Core-side and upstream handshake bundle of the task arbiter.
// master = arbiter view (drives upstream requests and core responses), slave = everything around it.
interface core_task_arbiter_if #(
   parameter int N_CORES = 4,
   parameter int TASK_W  = 128,
   parameter int SLOT_W  = 7,
   parameter int CHILD_W = 3,
   parameter int TT_W    = 4
);
   logic [N_CORES-1:0]              core_task_arvalid;
   logic [N_CORES-1:0][TT_W-1:0]    core_task_araddr;
   logic [N_CORES-1:0]              core_task_rvalid;
   logic [TASK_W-1:0]               core_task_rdata;
   logic [SLOT_W-1:0]               core_task_rslot;
   logic                            up_task_arvalid;
   logic [TT_W-1:0]                 up_task_araddr;
   logic                            up_task_rvalid;
   logic [TASK_W-1:0]               up_task_rdata;
   logic [SLOT_W-1:0]               up_task_rslot;
   logic [N_CORES-1:0]              core_finish_valid;
   logic [N_CORES-1:0][SLOT_W-1:0]  core_finish_slot;
   logic [N_CORES-1:0][CHILD_W-1:0] core_finish_num_children;
   logic [N_CORES-1:0]              core_finish_undo_log_write;
   logic [N_CORES-1:0]              core_finish_ready;
   logic                            up_finish_valid;
   logic                            up_finish_ready;
   logic [SLOT_W-1:0]               up_finish_slot;
   logic [CHILD_W-1:0]              up_finish_num_children;
   logic                            up_finish_undo_log_write;

   modport master (
      input  core_task_arvalid, core_task_araddr, up_task_rvalid, up_task_rdata, up_task_rslot,
             core_finish_valid, core_finish_slot, core_finish_num_children,
             core_finish_undo_log_write, up_finish_ready,
      output core_task_rvalid, core_task_rdata, core_task_rslot, up_task_arvalid, up_task_araddr,
             core_finish_ready, up_finish_valid, up_finish_slot, up_finish_num_children,
             up_finish_undo_log_write
   );

   modport slave (
      output core_task_arvalid, core_task_araddr, up_task_rvalid, up_task_rdata, up_task_rslot,
             core_finish_valid, core_finish_slot, core_finish_num_children,
             core_finish_undo_log_write, up_finish_ready,
      input  core_task_rvalid, core_task_rdata, core_task_rslot, up_task_arvalid, up_task_araddr,
             core_finish_ready, up_finish_valid, up_finish_slot, up_finish_num_children,
             up_finish_undo_log_write
   );
endinterface

// File: rtl/core_task_arbiter.sv
// Shares one task-dequeue port and one finish port among N_CORES cores using two
// independent round-robin arbiters whose grant stays locked until the transfer ends.
module core_task_arbiter #(
   parameter int N_CORES = 4,
   parameter int TASK_W  = 128,
   parameter int SLOT_W  = 7,
   parameter int CHILD_W = 3,
   parameter int TT_W    = 4
) (
   input logic               clk,
   input logic               rstn,
   core_task_arbiter_if.master bus
);
   localparam int PTR_W = $clog2(N_CORES);
   typedef logic [PTR_W-1:0] idx_t;

   typedef enum logic [1:0] {DQ_IDLE, DQ_REQ, DQ_RESP} dq_state_t;
   typedef enum logic       {FIN_IDLE, FIN_BUSY}       fin_state_t;

   // Lowest requester at or after ptr, wrapping; ptr itself if nobody asks.
   function automatic idx_t rr_pick(input logic [N_CORES-1:0] req, input idx_t ptr);
      idx_t win;
      idx_t cand;
      logic found;
      win   = ptr;
      found = 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
         cand = idx_t'((int'(ptr) + k) % N_CORES);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic idx_t rr_next(input idx_t g);
      return (int'(g) == N_CORES - 1) ? '0 : g + idx_t'(1);
   endfunction

   // ---------------- dequeue path ----------------
   dq_state_t          dq_state, dq_state_nxt;
   idx_t               dq_gnt, dq_gnt_nxt, dq_ptr, dq_ptr_nxt;
   logic               dq_cap;
   logic [TASK_W-1:0]  rdata_q;
   logic [SLOT_W-1:0]  rslot_q;
   logic               up_arv;
   logic [TT_W-1:0]    up_addr;
   logic [N_CORES-1:0] core_rv;

   always_comb begin
      dq_state_nxt = dq_state;
      dq_gnt_nxt   = dq_gnt;
      dq_ptr_nxt   = dq_ptr;
      dq_cap       = 1'b0;
      up_arv       = 1'b0;
      up_addr      = '0;
      core_rv      = '0;
      case (dq_state)
         DQ_IDLE: if (|bus.core_task_arvalid) begin
            dq_gnt_nxt   = rr_pick(bus.core_task_arvalid, dq_ptr);
            dq_state_nxt = DQ_REQ;
         end
         DQ_REQ: begin
            up_arv  = bus.core_task_arvalid[dq_gnt];
            up_addr = bus.core_task_araddr[dq_gnt];
            if (up_arv && bus.up_task_rvalid) begin
               dq_cap       = 1'b1;
               dq_state_nxt = DQ_RESP;
            end else if (!bus.core_task_arvalid[dq_gnt]) begin
               dq_state_nxt = DQ_IDLE;
            end
         end
         DQ_RESP: begin
            core_rv[dq_gnt] = 1'b1;
            dq_ptr_nxt      = rr_next(dq_gnt);
            dq_state_nxt    = DQ_IDLE;
         end
         default: dq_state_nxt = DQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dq_state <= DQ_IDLE;
         dq_gnt   <= '0;
         dq_ptr   <= '0;
         rdata_q  <= '0;
         rslot_q  <= '0;
      end else begin
         dq_state <= dq_state_nxt;
         dq_gnt   <= dq_gnt_nxt;
         dq_ptr   <= dq_ptr_nxt;
         if (dq_cap) begin
            rdata_q <= bus.up_task_rdata;
            rslot_q <= bus.up_task_rslot;
         end
      end
   end

   assign bus.up_task_arvalid  = up_arv;
   assign bus.up_task_araddr   = up_addr;
   assign bus.core_task_rvalid = core_rv;
   assign bus.core_task_rdata  = rdata_q;
   assign bus.core_task_rslot  = rslot_q;

   // ---------------- finish path ----------------
   fin_state_t         fin_state, fin_state_nxt;
   idx_t               fin_gnt, fin_gnt_nxt, fin_ptr, fin_ptr_nxt;
   logic               f_valid, f_ulw;
   logic [SLOT_W-1:0]  f_slot;
   logic [CHILD_W-1:0] f_nc;
   logic [N_CORES-1:0] f_ready;

   always_comb begin
      fin_state_nxt = fin_state;
      fin_gnt_nxt   = fin_gnt;
      fin_ptr_nxt   = fin_ptr;
      f_valid       = 1'b0;
      f_ulw         = 1'b0;
      f_slot        = '0;
      f_nc          = '0;
      f_ready       = '0;
      case (fin_state)
         FIN_IDLE: if (|bus.core_finish_valid) begin
            fin_gnt_nxt   = rr_pick(bus.core_finish_valid, fin_ptr);
            fin_state_nxt = FIN_BUSY;
         end
         FIN_BUSY: begin
            f_valid          = bus.core_finish_valid[fin_gnt];
            f_slot           = bus.core_finish_slot[fin_gnt];
            f_nc             = bus.core_finish_num_children[fin_gnt];
            f_ulw            = bus.core_finish_undo_log_write[fin_gnt];
            f_ready[fin_gnt] = bus.up_finish_ready & f_valid;
            if (f_valid && bus.up_finish_ready) begin
               fin_ptr_nxt   = rr_next(fin_gnt);
               fin_state_nxt = FIN_IDLE;
            end else if (!f_valid) begin
               fin_state_nxt = FIN_IDLE;
            end
         end
         default: fin_state_nxt = FIN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fin_state <= FIN_IDLE;
         fin_gnt   <= '0;
         fin_ptr   <= '0;
      end else begin
         fin_state <= fin_state_nxt;
         fin_gnt   <= fin_gnt_nxt;
         fin_ptr   <= fin_ptr_nxt;
      end
   end

   assign bus.core_finish_ready        = f_ready;
   assign bus.up_finish_valid          = f_valid;
   assign bus.up_finish_slot           = f_slot;
   assign bus.up_finish_num_children   = f_nc;
   assign bus.up_finish_undo_log_write = f_ulw;
endmodule

// File: doc/core_task_arbiter.md
Name: core_task_arbiter

Overview:
- Shares one tile's task-dequeue port and one finish-task port among N_CORES cores.
- Sits between the per-core controllers and the tile task unit / commit queue.
- Dequeue and finish each use an independent round-robin arbiter with a locked grant.
- Each core sees the same handshake it would see on a dedicated port. Dequeue responses arrive at the core one cycle after the upstream accept.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- TASK_W, 128, width of the packed task_t.
- SLOT_W, 7, width of cq_slice_slot_t.
- CHILD_W, 3, width of child_id_t.
- TT_W, 4, width of task_type_t.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- core_task_arvalid  in  N_CORES  per-core dequeue request; held high until that core's rvalid
- core_task_araddr  in  N_CORES*TT_W  per-core requested task type
- core_task_rvalid  out  N_CORES  one-cycle dequeue response pulse
- core_task_rdata  out  TASK_W  dequeued task; common bus, valid with rvalid
- core_task_rslot  out  SLOT_W  CQ slot of the dequeued task; common bus
- up_task_arvalid  out  1  dequeue request to the task unit
- up_task_araddr  out  TT_W  task type presented upstream
- up_task_rvalid  in  1  task unit accepts; fires in the same cycle as arvalid
- up_task_rdata  in  TASK_W  task from the task unit
- up_task_rslot  in  SLOT_W  slot from the task unit
- core_finish_valid  in  N_CORES  per-core finish request
- core_finish_slot  in  N_CORES*SLOT_W  per-core finish slot
- core_finish_num_children  in  N_CORES*CHILD_W  per-core child count
- core_finish_undo_log_write  in  N_CORES  per-core undo-log-written flag
- core_finish_ready  out  N_CORES  per-core finish accept
- up_finish_valid  out  1  finish request to the CQ
- up_finish_ready  in  1  CQ accept
- up_finish_slot  out  SLOT_W  finish slot
- up_finish_num_children  out  CHILD_W  child count
- up_finish_undo_log_write  out  1  undo-log-written flag

Behaviour:
- Reset: all state registers clear asynchronously on rstn low.
  - dq_state=DQ_IDLE, fin_state=FIN_IDLE, dq_ptr=0, fin_ptr=0.
  - All outputs are 0, including the rdata and rslot registers.
- Round-robin pick: lowest index i ≥ ptr among asserted requests, wrapping modulo N_CORES.
  - ptr ← winner+1 (mod N_CORES), updated only on a completed transfer.
- Dequeue FSM:
  - DQ_IDLE: if |core_task_arvalid, latch dq_gnt=pick and go to DQ_REQ. No upstream request this cycle.
  - DQ_REQ:
    - up_task_arvalid = core_task_arvalid[dq_gnt]; up_task_araddr = araddr slice dq_gnt.
    - If up_task_arvalid & up_task_rvalid: register up_task_rdata and up_task_rslot, go to DQ_RESP.
    - Else if core_task_arvalid[dq_gnt]==0 (core withdrew): go to DQ_IDLE; dq_ptr is unchanged.
  - DQ_RESP:
    - core_task_rvalid[dq_gnt]=1 for exactly this cycle.
    - dq_ptr ← dq_gnt+1; go to DQ_IDLE.
    - The core's held arvalid is still high in this cycle, so the core sees arvalid & rvalid.
  - Minimum spacing is 3 cycles per dequeue. At most one rvalid bit is high in any cycle.
  - up_task_rvalid outside DQ_REQ is ignored; it is not latched.
- Finish FSM:
  - FIN_IDLE: if |core_finish_valid, latch fin_gnt=pick and go to FIN_BUSY.
  - FIN_BUSY:
    - The granted core's valid, slot, num_children and undo_log_write drive the up_finish_* outputs combinationally.
    - core_finish_ready[fin_gnt] = up_finish_ready & core_finish_valid[fin_gnt]; all other ready bits are 0.
    - On handshake: fin_ptr ← fin_gnt+1, go to FIN_IDLE.
    - If the granted core drops valid without a handshake: go to FIN_IDLE; pointer is unchanged.
  - One accepted finish per 2 cycles at most.
- The two FSMs are independent. A core may hold a dequeue grant and a finish grant in the same cycle.
- Reset mid-transfer: any latched task is discarded and no rvalid is emitted. Cores restart their own handshakes after reset.
- Outputs are defined for any N_CORES in range. A grant index ≥ N_CORES is unreachable.

Test Plan:
- Single request: core 2 arvalid, araddr=3; task unit rvalid in the first DQ_REQ cycle with slot=0x15.
  - up_task_arvalid high in cycle 1, up_task_araddr=3.
  - core_task_rvalid=4'b0100 in cycle 2, rslot=0x15.
  - dq_ptr=3.
- Fairness: cores 0–3 hold arvalid; task unit always accepts.
  - Grant order is 0,1,2,3,0. Each rvalid is one pulse, spaced exactly 3 cycles apart.
- Backpressure and withdraw: core 1 granted, task unit silent 5 cycles, core 1 drops arvalid while core 3 is requesting.
  - Return to DQ_IDLE with no rvalid. Core 3 is granted next; dq_ptr stays 0 until core 3 completes.
- Finish contention: cores 0 and 2 finish_valid with slots 0x04/0x40; up_finish_ready low 4 cycles, then high.
  - Core 0 is forwarded, and its slot 0x04 is held stable while ready is low.
  - Core 2 gets no ready while core 0 holds the grant.
  - Core 2 is forwarded after core 0's handshake.
- Concurrent paths: core 1 dequeue and core 1 finish in the same cycles.
  - Both complete with independent latencies (3 and 2 cycles).
- Async reset asserted in DQ_RESP:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, no stale rvalid appears and both pointers are 0.
